// File: rtl/md5_chunk_dispatcher.sv
// rtl/md5_chunk_dispatcher.sv - round-robin chunk issuer for an array of MD5 search cores
// Optional DISPATCH_STATS_EN adds grant and run-cycle counters.
module md5_chunk_dispatcher #(
    parameter int N_CORES    = 4,
    parameter int SPACE_BITS = 29,
    parameter int CHUNK_BITS = 20
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pause,
    input  logic                          step,
    input  logic [N_CORES-1:0]            core_req,
    input  logic [N_CORES-1:0]            core_busy,
    input  logic [N_CORES-1:0]            core_found,
    output logic [N_CORES-1:0]            core_grant,
    output logic [SPACE_BITS-1:0]         chunk_base,
    output logic                          running,
    output logic                          done,
    output logic                          found,
    output logic [$clog2(N_CORES)-1:0]    found_core
`ifdef DISPATCH_STATS_EN
    ,
    output logic [SPACE_BITS-CHUNK_BITS:0] chunks_issued,
    output logic [31:0]                    run_cycles
`endif
);

    localparam int IW = $clog2(N_CORES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_PAUSED = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [SPACE_BITS-1:0] CHUNK_SIZE = SPACE_BITS'(1) << CHUNK_BITS;

    logic [2:0]            state;
    logic [IW-1:0]         rr;
    logic [SPACE_BITS-1:0] next_base;
    logic [N_CORES-1:0]    blocked;

    logic [N_CORES-1:0]    eligible;
    logic [N_CORES-1:0]    blocked_nxt;
    logic                  grant_en;
    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic                  do_grant;
    logic                  found_ev;
    logic [IW-1:0]         low_idx;
    logic [SPACE_BITS-1:0] nb_inc;
    logic                  wrap;
    logic                  active;

    assign active = (state == S_RUN) || (state == S_PAUSED) || (state == S_DRAIN);

    always_comb begin
        int      idx;
        logic [IW-1:0] idx_w;
        idx        = 0;
        idx_w      = '0;
        eligible   = core_req & ~blocked;
        pick_valid = 1'b0;
        pick_idx   = '0;
        // Scan upward from the round-robin pointer, wrapping past the top core.
        for (int k = 0; k < N_CORES; k++) begin
            idx   = (int'(rr) + k) % N_CORES;
            idx_w = IW'(idx);
            if (!pick_valid && eligible[idx_w]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_w;
            end
        end

        low_idx = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (core_found[k]) low_idx = IW'(k);
        end

        found_ev = (|core_found) && !found && active;
        grant_en = !(|core_found) &&
                   (((state == S_RUN) && !pause) || ((state == S_PAUSED) && step));
        do_grant = grant_en && pick_valid;

        nb_inc = next_base + CHUNK_SIZE;
        wrap   = (nb_inc == '0);

        // A granted core must drop req once before it becomes eligible again.
        blocked_nxt = blocked & core_req;
        if (do_grant) blocked_nxt[pick_idx] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= S_IDLE;
            rr         <= '0;
            next_base  <= '0;
            blocked    <= '0;
            core_grant <= '0;
            chunk_base <= '0;
            found      <= 1'b0;
            found_core <= '0;
        end else begin
            core_grant <= '0;
            blocked    <= blocked_nxt;

            if (do_grant) begin
                core_grant <= N_CORES'(1) << pick_idx;
                chunk_base <= next_base;
                next_base  <= nb_inc;
                rr         <= (pick_idx == IW'(N_CORES - 1)) ? '0 : pick_idx + 1'b1;
            end

            if (found_ev) begin
                found      <= 1'b1;
                found_core <= low_idx;
            end

            case (state)
                S_IDLE: begin
                    if (start) state <= S_RUN;
                end
                S_RUN: begin
                    if (found_ev || (do_grant && wrap)) state <= S_DRAIN;
                    else if (pause)                     state <= S_PAUSED;
                end
                S_PAUSED: begin
                    if (found_ev || (do_grant && wrap)) state <= S_DRAIN;
                    else if (!pause)                    state <= S_RUN;
                end
                S_DRAIN: begin
                    if (core_busy == '0) state <= S_DONE;
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign running = (state == S_RUN) && !pause;
    assign done    = (state == S_DONE);

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            chunks_issued <= '0;
            run_cycles    <= '0;
        end else begin
            if (do_grant) chunks_issued <= chunks_issued + 1'b1;
            if (active && (run_cycles != '1)) run_cycles <= run_cycles + 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_md5_chunk_dispatcher.sv
// tb/tb_md5_chunk_dispatcher.sv - directed self-checking bench for md5_chunk_dispatcher
// Define DISPATCH_STATS_EN to also check the statistics counters.
module tb_md5_chunk_dispatcher;

    logic        CLK = 1'b0;
    logic        reset, start, pause, step;
    logic [3:0]  core_req, core_busy, core_found;
    logic [3:0]  core_grant;
    logic [28:0] chunk_base;
    logic        running, done, found;
    logic [1:0]  found_core;

    logic [3:0]  core_req5;
    logic [3:0]  core_grant5;
    logic [28:0] chunk_base5;
    logic        running5, done5, found5;
    logic [1:0]  found_core5;

`ifdef DISPATCH_STATS_EN
    logic [2:0]  chunks_issued;
    logic [31:0] run_cycles;
    logic [9:0]  chunks_issued5;
    logic [31:0] run_cycles5;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    md5_chunk_dispatcher #(.N_CORES(4), .SPACE_BITS(29), .CHUNK_BITS(27)) dut (
        .CLK(CLK), .reset(reset), .start(start), .pause(pause), .step(step),
        .core_req(core_req), .core_busy(core_busy), .core_found(core_found),
        .core_grant(core_grant), .chunk_base(chunk_base), .running(running),
        .done(done), .found(found), .found_core(found_core)
`ifdef DISPATCH_STATS_EN
        , .chunks_issued(chunks_issued), .run_cycles(run_cycles)
`endif
    );

    md5_chunk_dispatcher #(.N_CORES(4), .SPACE_BITS(29), .CHUNK_BITS(20)) dut5 (
        .CLK(CLK), .reset(reset), .start(start), .pause(pause), .step(step),
        .core_req(core_req5), .core_busy(core_busy), .core_found(core_found),
        .core_grant(core_grant5), .chunk_base(chunk_base5), .running(running5),
        .done(done5), .found(found5), .found_core(found_core5)
`ifdef DISPATCH_STATS_EN
        , .chunks_issued(chunks_issued5), .run_cycles(run_cycles5)
`endif
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0;
        core_req = '0; core_busy = '0; core_found = '0; core_req5 = '0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (core_grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b expected 0000", core_grant); end
        n_cmp++; if (chunk_base !== 29'h0) begin n_bad++; $display("FAIL reset_base: got %h expected 0", chunk_base); end
        n_cmp++; if ({running, done, found} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {running, done, found}); end
        n_cmp++; if (found_core !== 2'd0) begin n_bad++; $display("FAIL reset_found_core: got %0d expected 0", found_core); end
    endtask

    task automatic test_full_sweep;
        logic [3:0]  eg;
        logic [28:0] eb;
        logic        er;
`ifdef DISPATCH_STATS_EN
        logic [31:0] rc;
`endif
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        core_req = 4'b1111; core_busy = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick;
            eg = 4'b0001 << i;
            eb = 29'(i) << 27;
            er = (i < 3);
            n_cmp++; if (core_grant !== eg) begin n_bad++; $display("FAIL sweep_grant%0d: got %b expected %b", i, core_grant, eg); end
            n_cmp++; if (chunk_base !== eb) begin n_bad++; $display("FAIL sweep_base%0d: got %h expected %h", i, chunk_base, eb); end
            n_cmp++; if (running !== er) begin n_bad++; $display("FAIL sweep_running%0d: got %b expected %b", i, running, er); end
        end
        tick;
        n_cmp++; if (core_grant !== 4'b0) begin n_bad++; $display("FAIL drain_no_grant: got %b expected 0000", core_grant); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL drain_done_early: got %b expected 0", done); end
        core_busy = 4'b0000;
        tick;
        n_cmp++; if ({done, found, running} !== 3'b100) begin n_bad++; $display("FAIL sweep_done: got %b expected 100", {done, found, running}); end
        start = 1'b1; tick; start = 1'b0; tick;
        n_cmp++; if ({done, running, core_grant} !== 6'b100000) begin n_bad++; $display("FAIL done_held: got %b expected 100000", {done, running, core_grant}); end
`ifdef DISPATCH_STATS_EN
        n_cmp++; if (chunks_issued !== 3'd4) begin n_bad++; $display("FAIL stats_chunks: got %0d expected 4", chunks_issued); end
        n_cmp++; if (run_cycles !== 32'd6) begin n_bad++; $display("FAIL stats_cycles: got %0d expected 6", run_cycles); end
        rc = run_cycles;
        tick; tick; tick;
        n_cmp++; if (run_cycles !== rc) begin n_bad++; $display("FAIL stats_frozen: got %0d expected %0d", run_cycles, rc); end
`endif
        core_req = '0;
    endtask

    task automatic test_found_wins;
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        core_req = 4'b0001; core_found = 4'b0110; core_busy = 4'b0001;
        tick;
        core_found = 4'b0000;
        n_cmp++; if (core_grant !== 4'b0) begin n_bad++; $display("FAIL found_no_grant: got %b expected 0000", core_grant); end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL found_latch: got %b expected 1", found); end
        n_cmp++; if (found_core !== 2'd1) begin n_bad++; $display("FAIL found_core: got %0d expected 1", found_core); end
        n_cmp++; if ({running, done} !== 2'b00) begin n_bad++; $display("FAIL found_drain: got %b expected 00", {running, done}); end
        core_found = 4'b1000;
        tick;
        core_found = 4'b0000;
        n_cmp++; if (found_core !== 2'd1) begin n_bad++; $display("FAIL found_second_ignored: got %0d expected 1", found_core); end
        n_cmp++; if ({core_grant, done} !== 5'b00000) begin n_bad++; $display("FAIL drain_hold: got %b expected 00000", {core_grant, done}); end
        core_busy = 4'b0000;
        tick;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL found_done: got %b expected 1", done); end
        core_req = '0;
    endtask

    task automatic test_pause_step;
        int grants;
        do_reset;
        pause = 1'b1; core_req = 4'b0001;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        n_cmp++; if ({core_grant, running} !== 5'b00000) begin n_bad++; $display("FAIL paused_no_grant: got %b expected 00000", {core_grant, running}); end
        step = 1'b1; tick; step = 1'b0;
        n_cmp++; if (core_grant !== 4'b0001) begin n_bad++; $display("FAIL step_grant: got %b expected 0001", core_grant); end
        n_cmp++; if (chunk_base !== 29'h0) begin n_bad++; $display("FAIL step_base: got %h expected 0", chunk_base); end
        grants = 0;
        for (int i = 0; i < 4; i++) begin tick; if (core_grant != 4'b0) grants++; end
        n_cmp++; if (grants !== 0) begin n_bad++; $display("FAIL step_single: got %0d extra grants expected 0", grants); end
        core_req = 4'b0000;
        step = 1'b1; tick; step = 1'b0;
        n_cmp++; if (core_grant !== 4'b0) begin n_bad++; $display("FAIL step_no_req: got %b expected 0000", core_grant); end
        tick;
        n_cmp++; if (core_grant !== 4'b0) begin n_bad++; $display("FAIL step_not_remembered: got %b expected 0000", core_grant); end
        pause = 1'b0; tick;
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL unpause_running: got %b expected 1", running); end
    endtask

    task automatic test_reset_mid_run;
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        core_req = 4'b1111; core_busy = 4'b0011;
        tick; tick;
        n_cmp++; if (chunk_base !== 29'h8000000) begin n_bad++; $display("FAIL mid_second_base: got %h expected 8000000", chunk_base); end
        reset = 1'b1; tick; reset = 1'b0;
        n_cmp++; if ({core_grant, running, done, found, found_core} !== 9'b0) begin n_bad++; $display("FAIL mid_reset_outputs: got %b expected 0", {core_grant, running, done, found, found_core}); end
        n_cmp++; if (chunk_base !== 29'h0) begin n_bad++; $display("FAIL mid_reset_base: got %h expected 0", chunk_base); end
        start = 1'b1; tick; start = 1'b0; tick;
        n_cmp++; if ({core_grant, chunk_base} !== {4'b0001, 29'h0}) begin n_bad++; $display("FAIL restart_first: got %b/%h expected 0001/0", core_grant, chunk_base); end
        core_req = '0; core_busy = '0;
    endtask

    task automatic test_long_sweep;
        int          n;
        logic [28:0] eb;
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        core_req5 = 4'b0001; core_busy = 4'b0001;
        n = 0; eb = '0;
        for (int c = 0; c < 3000 && n < 512; c++) begin
            tick;
            core_req5 = 4'b0001;
            if (core_grant5 != 4'b0) begin
                n_cmp++; if (chunk_base5 !== eb) begin n_bad++; $display("FAIL long_base%0d: got %h expected %h", n, chunk_base5, eb); end
                eb = eb + 29'h100000;
                n++;
                core_req5 = 4'b0000;
            end
        end
        n_cmp++; if (n !== 512) begin n_bad++; $display("FAIL long_count: got %0d expected 512", n); end
        n_cmp++; if (chunk_base5 !== 29'h1FF00000) begin n_bad++; $display("FAIL long_last: got %h expected 1ff00000", chunk_base5); end
        n_cmp++; if ({running5, done5} !== 2'b00) begin n_bad++; $display("FAIL long_drain: got %b expected 00", {running5, done5}); end
        core_busy = 4'b0000; tick; tick;
        n_cmp++; if ({done5, core_grant5} !== 5'b10000) begin n_bad++; $display("FAIL long_done: got %b expected 10000", {done5, core_grant5}); end
        core_req5 = '0;
    endtask

    initial begin
        test_reset;
        test_full_sweep;
        test_found_wins;
        test_pause_step;
        test_reset_mid_run;
        test_long_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
